xedge_event_sched: RTL and testbench
====================================

// Module: xedge_event_sched
// PURPOSE
//  Samples NCH encoded 4-state monitor signals, classifies each change as posedge/negedge/any-change under
//  Verilog 4-state edge rules (0->X counts as posedge, 1->X as negedge), and queues one pending event per channel.
//  A round-robin scheduler shares one downstream event port (valid/ready) among all channels.
//  Sits between the xprop monitor taps and the event-consumer/trace logic.
// PARAMETERS
//  NCH    4  number of monitored channels (2..32)
//  CHW    2  width of evt_ch; must be >= $clog2(NCH)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  sig_in     in   2*NCH   per channel {is_x, val}; is_x=1 means X/Z, val then ignored
//  cfg_we     in   1       write mode of channel cfg_ch
//  cfg_ch     in   CHW     channel to configure
//  cfg_mode   in   2       0=OFF 1=ANY 2=POS 3=NEG
//  evt_valid  out  1       event available
//  evt_ch     out  CHW     channel of the event
//  evt_kind   out  2       1=ANY 2=POS 3=NEG (equals channel mode at detection)
//  evt_ready  in   1       consumer accepts event when evt_valid&&evt_ready
//  ovf        out  NCH     sticky per-channel overflow (edge lost)
//  ovf_clr    in   1       clears all ovf bits next cycle
// BEHAVIOUR
//  Reset: evt_valid=0, evt_ch=0, evt_kind=0, ovf=0, all modes OFF, pending=0, prev=X, rr pointer=0, primed=0.
//  Sampling: each rising clk, cur=sig_in[i], compared with prev[i]; prev[i]<=cur every cycle.
//  First cycle after reset release: primed<=1, no edges detected (prev is not valid).
//  Edge classes (prev->cur, 3 states 0/1/X): POS = 0->1, 0->X, X->1; NEG = 1->0, 1->X, X->0;
//   ANY = any change of state; X->X and equal values never an edge; val bits under is_x never compared.
//  Channel in mode OFF never detects; detection = class matches mode (ANY mode fires on POS or NEG too).
//  Pending: detection sets pending[i] at the same edge; kind latched with it.
//  Overflow: detection while pending[i]=1 and channel i not granted this cycle -> ovf[i]<=1, event dropped
//   (older pending event kept). Detection on the channel granted this cycle -> pending stays 1, no overflow.
//  ovf_clr and a new overflow in same cycle: new overflow wins (bit stays 1).
//  Scheduler: output register loads when !evt_valid || evt_ready; picks first pending channel starting at
//   rr pointer, wrapping NCH-1 -> 0; grant clears that pending bit; pointer <= granted+1 (mod NCH).
//   No pending -> evt_valid<=0 on load. evt_valid/ch/kind held stable while evt_valid && !evt_ready.
//  Latency: input change at edge t -> pending at t -> evt_valid at t+1 (output free); full throughput 1/cycle.
//  cfg_we: mode updated next edge; clears pending[i] and ovf[i] of that channel; event already in output
//   register is unaffected. Detection in the cfg_we cycle uses the old mode, then is discarded by the clear.
//  Reset asserted mid-operation: all state returns to reset values asynchronously; in-flight event lost.
// STRUCTURE
//  Package xedge_pkg: mode/kind enum (OFF/ANY/POS/NEG), 2-bit 4-state encoding constants (ENC0, ENC1, ENCX),
//   function xedge_class(prev,cur) returning {pos,neg,any}.
//  Sub-module xedge_rr_arb: NCH-wide round-robin pick (req, ptr -> gnt_onehot, gnt_idx, any); combinational.
//  Top: prev/pending/kind/ovf arrays, mode regs, output register, pointer.
// TESTING
//  ch0 POS, sig 0->X -> evt_valid next cycle, evt_ch=0, evt_kind=2; ch0 NEG same stimulus -> no event.
//  ch1 NEG, sig 1->X then X->0 with ready=1 -> two events, kind=3 each; ch1 ANY, X->X with val toggling -> none.
//  ch0..3 ANY, all 0->1 same cycle, ready=1 -> evt_ch 0,1,2,3 on consecutive cycles; then ch0,2 again -> 0,2.
//  ready=0, ch2 POS edges 0->1->0->1 -> one event held stable, ovf[2]=1; ovf_clr -> ovf=0.
//  evt_valid held 3 cycles with ready=0 -> ch/kind unchanged; pointer advances only on acceptance.
//  rst_n low with pending + valid event -> all outputs 0 immediately; first post-reset sample no event.

Source files
------------

// File: rtl/xedge_pkg.sv
// Shared types and helpers for the 4-state edge event scheduler.
//   xedge_mode_e   : channel mode / event kind (OFF, ANY, POS, NEG)
//   ENC0/ENC1/ENCX : {is_x, val} encoding of a sampled monitor signal
//   xedge_class()  : classify a prev->cur transition as {pos, neg, any}
//   xedge_hit()    : does a transition class fire for a given mode
package xedge_pkg;

    typedef enum logic [1:0] {
        MODE_OFF = 2'd0,
        MODE_ANY = 2'd1,
        MODE_POS = 2'd2,
        MODE_NEG = 2'd3
    } xedge_mode_e;

    localparam logic [1:0] ENC0 = 2'b00;
    localparam logic [1:0] ENC1 = 2'b01;
    localparam logic [1:0] ENCX = 2'b10;   // val bit is don't-care whenever is_x=1

    typedef struct packed {
        logic pos;
        logic neg;
        logic any;
    } xedge_class_t;

    // Verilog 4-state edge rules: leaving 0 or arriving at 1 (from X) is a
    // posedge, leaving 1 or arriving at 0 (from X) is a negedge. The val bit
    // is only looked at when is_x is clear, so X->X never registers.
    function automatic xedge_class_t xedge_class(input logic [1:0] prev, input logic [1:0] cur);
        xedge_class_t c;
        logic p_x, p_v, c_x, c_v;
        p_x   = prev[1];
        p_v   = prev[0];
        c_x   = cur[1];
        c_v   = cur[0];
        c.pos = (!p_x && !p_v && (c_x || c_v)) || (p_x && !c_x && c_v);
        c.neg = (!p_x &&  p_v && (c_x || !c_v)) || (p_x && !c_x && !c_v);
        c.any = c.pos || c.neg;
        return c;
    endfunction

    function automatic logic xedge_hit(input xedge_mode_e mode, input xedge_class_t c);
        logic hit;
        case (mode)
            MODE_ANY: hit = c.any;
            MODE_POS: hit = c.pos;
            MODE_NEG: hit = c.neg;
            default:  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/xedge_rr_arb.sv
// Combinational round-robin picker.
//   req        : per-channel request vector
//   ptr        : highest-priority channel this cycle
//   gnt_onehot : one-hot grant
//   gnt_idx    : index of the granted channel
//   any        : at least one request present
module xedge_rr_arb
    import xedge_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] ptr,
    output logic [NCH-1:0] gnt_onehot,
    output logic [CHW-1:0] gnt_idx,
    output logic           any
);

    // First pass searches ptr..NCH-1; if nothing is found there, the second
    // pass takes the lowest request overall, which is the wrap-around winner.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!any && req[i] && (CHW'(i) >= ptr)) begin
                any           = 1'b1;
                gnt_onehot[i] = 1'b1;
                gnt_idx       = CHW'(i);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!any && req[i]) begin
                any           = 1'b1;
                gnt_onehot[i] = 1'b1;
                gnt_idx       = CHW'(i);
            end
        end
    end

endmodule

// File: rtl/xedge_event_sched.sv
// 4-state edge detector with one pending event per channel and a
// round-robin shared valid/ready event port.
//   clk, rst_n         : clock, async active-low reset
//   sig_in             : per channel {is_x, val}
//   cfg_we/ch/mode     : write a channel mode (clears its pending and ovf)
//   evt_valid/ch/kind  : event output register, held while !evt_ready
//   evt_ready          : consumer handshake
//   ovf                : sticky per-channel lost-edge flags
//   ovf_clr            : clear all ovf bits (a same-cycle overflow wins)
module xedge_event_sched
    import xedge_pkg::*;
#(
    parameter int NCH = 4,
    parameter int CHW = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2*NCH-1:0] sig_in,
    input  logic             cfg_we,
    input  logic [CHW-1:0]   cfg_ch,
    input  logic [1:0]       cfg_mode,
    output logic             evt_valid,
    output logic [CHW-1:0]   evt_ch,
    output logic [1:0]       evt_kind,
    input  logic             evt_ready,
    output logic [NCH-1:0]   ovf,
    input  logic             ovf_clr
);

    logic [NCH-1:0][1:0] prev_q;
    logic                primed_q;
    logic [NCH-1:0]      pending_q;
    xedge_mode_e         mode_q [NCH];
    xedge_mode_e         kind_q [NCH];
    logic [CHW-1:0]      ptr_q;

    logic [NCH-1:0]      det;
    logic [NCH-1:0]      cfg_hit;
    logic [NCH-1:0]      gnt_onehot;
    logic [NCH-1:0]      take;
    logic [CHW-1:0]      gnt_idx;
    logic                gnt_any;
    logic                load;

    assign load = !evt_valid || evt_ready;
    assign take = gnt_onehot & {NCH{load}};

    // prev_q is meaningless on the first cycle out of reset, so primed_q
    // gates detection until one real sample has been captured.
    always_comb begin
        det     = '0;
        cfg_hit = '0;
        for (int i = 0; i < NCH; i++) begin
            det[i]     = primed_q && xedge_hit(mode_q[i], xedge_class(prev_q[i], sig_in[2*i +: 2]));
            cfg_hit[i] = cfg_we && (cfg_ch == CHW'(i));
        end
    end

    xedge_rr_arb #(
        .NCH (NCH),
        .CHW (CHW)
    ) u_arb (
        .req        (pending_q),
        .ptr        (ptr_q),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (gnt_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= {NCH{ENCX}};
            primed_q  <= 1'b0;
            pending_q <= '0;
            ovf       <= '0;
            ptr_q     <= '0;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_kind  <= '0;
            for (int i = 0; i < NCH; i++) begin
                mode_q[i] <= MODE_OFF;
                kind_q[i] <= MODE_OFF;
            end
        end else begin
            prev_q   <= sig_in;
            primed_q <= 1'b1;

            if (load) begin
                evt_valid <= gnt_any;
                evt_ch    <= gnt_any ? gnt_idx : '0;
                evt_kind  <= gnt_any ? kind_q[gnt_idx] : MODE_OFF;
                if (gnt_any) begin
                    ptr_q <= (gnt_idx == CHW'(NCH-1)) ? '0 : gnt_idx + CHW'(1);
                end
            end

            for (int i = 0; i < NCH; i++) begin
                if (cfg_hit[i]) begin
                    // Any detection this cycle used the old mode and is discarded.
                    mode_q[i]    <= xedge_mode_e'(cfg_mode);
                    pending_q[i] <= 1'b0;
                    ovf[i]       <= 1'b0;
                end else if (det[i] && pending_q[i] && !take[i]) begin
                    // Slot occupied: keep the older event, flag the loss.
                    ovf[i] <= 1'b1;
                end else begin
                    if (det[i]) begin
                        pending_q[i] <= 1'b1;
                        kind_q[i]    <= mode_q[i];
                    end else if (take[i]) begin
                        pending_q[i] <= 1'b0;
                    end
                    if (ovf_clr) begin
                        ovf[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_xedge_event_sched.sv
// Self-checking bench for xedge_event_sched: a channel-level behavioural
// model compared on every negedge, plus hand-computed directed expectations.
module tb_xedge_event_sched;
    import xedge_pkg::*;

    localparam int NCH = 4;
    localparam int CHW = 2;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic [2*NCH-1:0] sig_in    = '0;
    logic             cfg_we    = 1'b0;
    logic [CHW-1:0]   cfg_ch    = '0;
    logic [1:0]       cfg_mode  = '0;
    logic             evt_valid;
    logic [CHW-1:0]   evt_ch;
    logic [1:0]       evt_kind;
    logic             evt_ready = 1'b1;
    logic [NCH-1:0]   ovf;
    logic             ovf_clr   = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    xedge_event_sched #(.NCH(NCH), .CHW(CHW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_mode  (cfg_mode),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_kind  (evt_kind),
        .evt_ready (evt_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Signal states: 0, 1, 2 (=X). Modes: 0 OFF, 1 ANY, 2 POS, 3 NEG.
    int m_prev [NCH] = '{default: 2};
    int m_mode [NCH] = '{default: 0};
    int m_kind [NCH] = '{default: 0};
    bit m_pend [NCH] = '{default: 0};
    bit m_ovf  [NCH] = '{default: 0};
    bit m_primed = 0;
    int m_ptr    = 0;
    bit m_valid  = 0;
    int m_ch     = 0;
    int m_kout   = 0;

    function automatic int st(input logic [1:0] e);
        return e[1] ? 2 : int'(e[0]);
    endfunction

    function automatic bit fires(input int mode, input int p, input int c);
        bit is_pos, is_neg;
        is_pos = (p == 0 && c != 0) || (p == 2 && c == 1);
        is_neg = (p == 1 && c != 1) || (p == 2 && c == 0);
        case (mode)
            1:       return p != c;
            2:       return is_pos;
            3:       return is_neg;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int g;
        bit ld;
        bit newovf;
        int cur [NCH];
        bit det [NCH];
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_prev[i] = 2; m_mode[i] = 0; m_kind[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
            end
            m_primed = 0; m_ptr = 0; m_valid = 0; m_ch = 0; m_kout = 0;
        end else begin
            ld = !m_valid || evt_ready;
            g  = -1;
            if (ld) begin
                for (int k = 0; k < NCH; k++) begin
                    if (g < 0 && m_pend[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                cur[i] = st(sig_in[2*i +: 2]);
                det[i] = m_primed && fires(m_mode[i], m_prev[i], cur[i]);
            end
            if (ld) begin
                m_valid = (g >= 0);
                m_ch    = (g >= 0) ? g : 0;
                m_kout  = (g >= 0) ? m_kind[g] : 0;
                if (g >= 0) m_ptr = (g + 1) % NCH;
            end
            for (int i = 0; i < NCH; i++) begin
                newovf = 0;
                if (g == i) m_pend[i] = 0;
                if (det[i]) begin
                    if (m_pend[i]) begin
                        m_ovf[i] = 1;
                        newovf   = 1;
                    end else begin
                        m_pend[i] = 1;
                        m_kind[i] = m_mode[i];
                    end
                end
                if (ovf_clr && !newovf) m_ovf[i] = 0;
                if (cfg_we && int'(cfg_ch) == i) begin
                    m_pend[i] = 0;
                    m_ovf[i]  = 0;
                    m_mode[i] = int'(cfg_mode);
                end
                m_prev[i] = cur[i];
            end
            m_primed = 1;
        end
    end

    always @(negedge clk) begin : compare
        int exp_ovf;
        if (rst_n) begin
            exp_ovf = 0;
            for (int i = 0; i < NCH; i++) if (m_ovf[i]) exp_ovf += (1 << i);
            chk("model_valid", int'(evt_valid), int'(m_valid));
            if (m_valid) begin
                chk("model_ch", int'(evt_ch), m_ch);
                chk("model_kind", int'(evt_kind), m_kout);
            end
            chk("model_ovf", int'(ovf), exp_ovf);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input int s, input bit v = 1'b0);
        sig_in[2*ch +: 2] = (s == 2) ? {1'b1, v} : ((s == 1) ? ENC1 : ENC0);
    endtask

    task automatic cfg(input int ch, input int mode);
        cfg_we   = 1'b1;
        cfg_ch   = CHW'(ch);
        cfg_mode = 2'(mode);
        step();
        cfg_we   = 1'b0;
    endtask

    task automatic expect_evt(input string name, input bit v, input int ch, input int kind);
        chk({name, "_valid"}, int'(evt_valid), int'(v));
        if (v) begin
            chk({name, "_ch"}, int'(evt_ch), ch);
            chk({name, "_kind"}, int'(evt_kind), kind);
        end
    endtask

    initial begin : watchdog
        #50000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete by %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        step(2);
        expect_evt("rst", 1'b0, 0, 0);
        chk("rst_ch", int'(evt_ch), 0);
        chk("rst_kind", int'(evt_kind), 0);
        chk("rst_ovf", int'(ovf), 0);
        rst_n = 1'b1;
        step(2);

        // ch0 POS, 0->X
        cfg(0, 2);
        set_ch(0, 2);
        step(); expect_evt("t1_pend", 1'b0, 0, 0);
        step(); expect_evt("t1_pos", 1'b1, 0, 2);
        step(); expect_evt("t1_drain", 1'b0, 0, 0);
        cfg(0, 0);
        set_ch(0, 0);
        step();
        // ch0 NEG, 0->X must not fire
        cfg(0, 3);
        set_ch(0, 2);
        step(); expect_evt("t1_neg_a", 1'b0, 0, 0);
        step(); expect_evt("t1_neg_b", 1'b0, 0, 0);
        cfg(0, 0);
        set_ch(0, 0);
        step();

        // ch1 NEG, 1->X then X->0
        set_ch(1, 1);
        step();
        cfg(1, 3);
        set_ch(1, 2);
        step(); expect_evt("t2_pend", 1'b0, 0, 0);
        step(); expect_evt("t2_1x", 1'b1, 1, 3);
        set_ch(1, 0);
        step(); expect_evt("t2_gap", 1'b0, 0, 0);
        step(); expect_evt("t2_x0", 1'b1, 1, 3);
        step(); expect_evt("t2_drain", 1'b0, 0, 0);
        // ch1 ANY, X->X with val toggling
        set_ch(1, 2, 1'b0);
        step();
        cfg(1, 1);
        for (int i = 0; i < 4; i++) begin
            set_ch(1, 2, i[0]);
            step(); expect_evt("t2_xx", 1'b0, 0, 0);
        end
        cfg(1, 0);
        set_ch(1, 0);
        step();

        // fresh reset so the pointer starts at 0
        #2 rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step(2);

        // all ANY, simultaneous 0->1
        for (int c = 0; c < NCH; c++) cfg(c, 1);
        for (int c = 0; c < NCH; c++) set_ch(c, 1);
        step(); expect_evt("t3_pend", 1'b0, 0, 0);
        for (int c = 0; c < NCH; c++) begin
            step(); expect_evt("t3_rr", 1'b1, c, 1);
        end
        step(); expect_evt("t3_idle", 1'b0, 0, 0);
        set_ch(0, 0);
        set_ch(2, 0);
        step(); expect_evt("t3b_pend", 1'b0, 0, 0);
        step(); expect_evt("t3b_a", 1'b1, 0, 1);
        step(); expect_evt("t3b_b", 1'b1, 2, 1);
        step(); expect_evt("t3b_idle", 1'b0, 0, 0);

        // ready=0, ch2 POS, overflow and ovf_clr
        cfg(2, 2);
        evt_ready = 1'b0;
        set_ch(2, 1); step(); expect_evt("t4_pend", 1'b0, 0, 0);
        set_ch(2, 0); step(); expect_evt("t4_first", 1'b1, 2, 2);
        set_ch(2, 1); step();
        set_ch(2, 0); step();
        set_ch(2, 1); step();
        chk("t4_ovf_set", int'(ovf), 4);
        expect_evt("t4_hold0", 1'b1, 2, 2);
        set_ch(2, 0); step(); expect_evt("t4_hold1", 1'b1, 2, 2);
        set_ch(2, 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t4_ovf_clr_vs_new", int'(ovf), 4);
        expect_evt("t4_hold2", 1'b1, 2, 2);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("t4_ovf_cleared", int'(ovf), 0);
        evt_ready = 1'b1;
        step(); expect_evt("t4_second", 1'b1, 2, 2);
        step(); expect_evt("t4_idle", 1'b0, 0, 0);

        // reset with a pending and a valid event in flight
        evt_ready = 1'b0;
        set_ch(0, 1);
        set_ch(3, 0);
        step(); expect_evt("t5_pend", 1'b0, 0, 0);
        step(); expect_evt("t5_valid", 1'b1, 3, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", int'(evt_valid), 0);
        chk("t5_rst_ch", int'(evt_ch), 0);
        chk("t5_rst_kind", int'(evt_kind), 0);
        chk("t5_rst_ovf", int'(ovf), 0);
        step();
        rst_n = 1'b1;
        evt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); expect_evt("t5_post", 1'b0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
